// File: rtl/uart_monitor_pkg.sv
// UART capture monitor: shared types and helpers.
// Used by the deframer, its FIFO and chip-level benches.
package uart_monitor_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Total line bits per character, start bit included.
  function automatic int frame_bits(
    input int data_bits,
    input int parity,
    input int stop_bits
  );
    return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with wrap-bit pointers; head word is
// read straight from storage and masked to zero when empty.
module sync_fifo
  import uart_monitor_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign occupancy = wr_ptr - rd_ptr;

  // A pop frees the slot first, so push into a full FIFO
  // is accepted when it coincides with a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_capture_monitor.sv
// UART receive monitor: synchronises a serial line,
// deframes characters and queues them with error flags.
module uart_capture_monitor
  import uart_monitor_pkg::*;
#(
  parameter int CLK_DIV   = 868,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 16
) (
  input  logic                     io_clock,
  input  logic                     io_reset,
  input  logic                     io_rxd,
  input  logic                     io_clearFlags,
  output logic                     io_data_valid,
  input  logic                     io_data_ready,
  output logic [DATA_BITS+1:0]     io_data_payload,
  output logic                     io_overflow,
  output logic [$clog2(DEPTH):0]   io_occupancy
);

  if (CLK_DIV < 4 || CLK_DIV > 65535) begin : g_bad_div
    $fatal(1, "CLK_DIV out of range");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $fatal(1, "DATA_BITS out of range");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $fatal(1, "PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $fatal(1, "STOP_BITS must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "DEPTH must be a power of two >= 2");
  end

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic ODD = (PARITY == int'(PAR_ODD));

  logic                 s1;
  logic                 rxs;
  rx_state_e            state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 frm_err;
  logic                 push_q;
  logic                 tick;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 ov_evt;

  assign tick   = (cnt == '0);
  assign pop    = io_data_valid && io_data_ready;
  assign ov_evt = push_q && full && !pop;
  assign io_data_valid = !empty;

  // Two-flop synchroniser for the asynchronous line.
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      s1  <= 1'b1;
      rxs <= 1'b1;
    end else begin
      s1  <= io_rxd;
      rxs <= s1;
    end
  end

  // Deframer: mid-bit sampling, push one cycle after last stop.
  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (state != RX_IDLE && !tick) cnt <= cnt - 1'b1;
      unique case (state)
        RX_IDLE: begin
          if (!rxs) begin
            state   <= RX_START;
            bit_cnt <= '0;
            cnt     <= HALF;
            par_err <= 1'b0;
            frm_err <= 1'b0;
          end
        end
        RX_START: begin
          if (tick) begin
            cnt   <= FULL;
            state <= rxs ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (tick) begin
            cnt   <= FULL;
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? RX_PARITY : RX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (tick) begin
            cnt     <= FULL;
            par_err <= ((^shreg) ^ rxs) != ODD;
            state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (tick) begin
            cnt <= FULL;
            if (!rxs) frm_err <= 1'b1;
            if (bit_cnt == LAST_STOP) begin
              state  <= RX_IDLE;
              push_q <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Sticky overflow; a new drop wins over a clear.
  always_ff @(posedge io_clock) begin
    if (io_reset)           io_overflow <= 1'b0;
    else if (ov_evt)        io_overflow <= 1'b1;
    else if (io_clearFlags) io_overflow <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (io_clock),
    .rst       (io_reset),
    .push      (push_q),
    .wdata     ({par_err, frm_err, shreg}),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .rdata     (io_data_payload),
    .occupancy (io_occupancy)
  );

endmodule

// File: tb/tb_uart_capture_monitor.sv
// Directed bench for uart_capture_monitor: three instances
// cover default format, 7E1 parity and a shallow FIFO.
module tb_uart_capture_monitor;
  import uart_monitor_pkg::*;

  localparam int D0 = 868;
  localparam int D1 = 16;
  localparam int D2 = 16;
  localparam int TMO = 2 * frame_bits(8, 0, 1) * D0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [3];
  logic rxd [3];
  logic clr [3];
  logic rdy [3];
  logic vld [3];
  logic ovf [3];
  logic [9:0] pl0;
  logic [8:0] pl1;
  logic [9:0] pl2;
  logic [4:0] oc0;
  logic [4:0] oc1;
  logic [2:0] oc2;

  int n_tests = 0;
  int n_fail  = 0;

  uart_capture_monitor u0 (
    .io_clock (clk), .io_reset (rst[0]), .io_rxd (rxd[0]),
    .io_clearFlags (clr[0]), .io_data_valid (vld[0]),
    .io_data_ready (rdy[0]), .io_data_payload (pl0),
    .io_overflow (ovf[0]), .io_occupancy (oc0)
  );

  uart_capture_monitor #(
    .CLK_DIV (D1), .DATA_BITS (7), .PARITY (1)
  ) u1 (
    .io_clock (clk), .io_reset (rst[1]), .io_rxd (rxd[1]),
    .io_clearFlags (clr[1]), .io_data_valid (vld[1]),
    .io_data_ready (rdy[1]), .io_data_payload (pl1),
    .io_overflow (ovf[1]), .io_occupancy (oc1)
  );

  uart_capture_monitor #(
    .CLK_DIV (D2), .DEPTH (4)
  ) u2 (
    .io_clock (clk), .io_reset (rst[2]), .io_rxd (rxd[2]),
    .io_clearFlags (clr[2]), .io_data_valid (vld[2]),
    .io_data_ready (rdy[2]), .io_data_payload (pl2),
    .io_overflow (ovf[2]), .io_occupancy (oc2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pl(input int id);
    case (id)
      0:       return 32'(pl0);
      1:       return 32'(pl1);
      default: return 32'(pl2);
    endcase
  endfunction

  function automatic logic [31:0] oc(input int id);
    case (id)
      0:       return 32'(oc0);
      1:       return 32'(oc1);
      default: return 32'(oc2);
    endcase
  endfunction

  // Drives one frame LSB first; ends on a negedge, line idle.
  task automatic send(input int id, input int div,
                      input logic [8:0] d, input int nd,
                      input bit has_par, input bit pbit,
                      input bit sbit);
    logic [11:0] f;
    int n;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < nd; i++) f[1+i] = d[i];
    n = 1 + nd;
    if (has_par) begin
      f[n] = pbit;
      n++;
    end
    f[n] = sbit;
    n++;
    for (int i = 0; i < n; i++) begin
      rxd[id] = f[i];
      repeat (div) @(negedge clk);
    end
    rxd[id] = 1'b1;
  endtask

  task automatic pop_expect(input int id, input string tag,
                            input logic [31:0] exp);
    int k;
    k = 0;
    while (!vld[id] && k < TMO) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, 32'(vld[id]), 32'd1);
    check(tag, pl(id), exp);
    rdy[id] = 1'b1;
    @(negedge clk);
    rdy[id] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      rxd[i] = 1'b1;
      clr[i] = 1'b0;
      rdy[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_valid0", 32'(vld[0]), 32'd0);
    check("rst_pl0", pl(0), 32'd0);
    check("rst_ovf0", 32'(ovf[0]), 32'd0);
    check("rst_occ0", oc(0), 32'd0);
    check("rst_occ2", oc(2), 32'd0);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge clk);

    // Short glitch on idle line must be rejected.
    rxd[0] = 1'b0;
    repeat (300) @(negedge clk);
    rxd[0] = 1'b1;
    repeat (600) @(negedge clk);
    check("glitch_valid", 32'(vld[0]), 32'd0);
    check("glitch_occ", oc(0), 32'd0);

    // Back-to-back frames at full rate.
    send(0, D0, 9'h55, 8, 1'b0, 1'b0, 1'b1);
    send(0, D0, 9'hA3, 8, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("b2b_occ", oc(0), 32'd2);
    pop_expect(0, "b2b_55", 32'h055);
    pop_expect(0, "b2b_a3", 32'h0A3);
    check("b2b_ovf", 32'(ovf[0]), 32'd0);
    check("b2b_occ_end", oc(0), 32'd0);

    // 7E1: wrong and correct parity.
    send(1, D1, 9'h41, 7, 1'b1, 1'b1, 1'b1);
    pop_expect(1, "par_bad_41", 32'h141);
    send(1, D1, 9'h41, 7, 1'b1, 1'b0, 1'b1);
    pop_expect(1, "par_ok_41", 32'h041);
    send(1, D1, 9'h07, 7, 1'b1, 1'b1, 1'b1);
    pop_expect(1, "par_ok_07", 32'h007);

    // Stop bit low, then a clean frame after idle.
    send(2, D2, 9'h7E, 8, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    pop_expect(2, "frm_7e", 32'h17E);
    send(2, D2, 9'h00, 8, 1'b0, 1'b0, 1'b1);
    pop_expect(2, "frm_00", 32'h000);
    repeat (40) @(negedge clk);
    check("frm_occ", oc(2), 32'd0);

    // Overflow: five frames into a four-deep FIFO.
    for (int i = 1; i <= 5; i++)
      send(2, D2, 9'(i * 17), 8, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("ovf_occ", oc(2), 32'd4);
    check("ovf_flag", 32'(ovf[2]), 32'd1);
    check("ovf_head", pl(2), 32'h011);
    repeat (10) @(negedge clk);
    check("ovf_head_hold", pl(2), 32'h011);
    pop_expect(2, "ovf_11", 32'h011);
    pop_expect(2, "ovf_22", 32'h022);
    pop_expect(2, "ovf_33", 32'h033);
    pop_expect(2, "ovf_44", 32'h044);
    check("ovf_occ_end", oc(2), 32'd0);
    check("ovf_sticky", 32'(ovf[2]), 32'd1);
    clr[2] = 1'b1;
    @(negedge clk);
    clr[2] = 1'b0;
    check("ovf_clear", 32'(ovf[2]), 32'd0);

    // Reset in the middle of the data bits of 0x3C.
    rxd[2] = 1'b0;
    repeat (D2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd[2] = (i >= 2);
      repeat (D2) @(negedge clk);
    end
    rst[2] = 1'b1;
    repeat (2) @(negedge clk);
    rxd[2] = 1'b1;
    repeat (40) @(negedge clk);
    rst[2] = 1'b0;
    @(negedge clk);
    check("mrst_valid", 32'(vld[2]), 32'd0);
    check("mrst_occ", oc(2), 32'd0);
    send(2, D2, 9'hC3, 8, 1'b0, 1'b0, 1'b1);
    pop_expect(2, "mrst_c3", 32'h0C3);
    repeat (200) @(negedge clk);
    check("mrst_valid_end", 32'(vld[2]), 32'd0);
    check("mrst_ovf", 32'(ovf[2]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
